// File: rtl/arm_multicycle_sequencer.sv
// Multi-cycle control unit for the ARM calculator datapath.
// Sequences FETCH/DECODE/EXEC/[MEM]/COMMIT, gates write strobes and holds NZCV flags.
module arm_multicycle_sequencer #(
  parameter logic [31:0] HALT_INSTR = 32'hEF000000,
  parameter bit          AUTO_RUN   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Run,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic        Halted,
  output logic        Undef
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_COMMIT, S_HALT
  } state_t;

  state_t      r_state;
  logic [31:0] r_ir;
  logic        r_pass;
  logic        r_mem;
  logic        r_str;
  logic        r_regwr;
  logic        r_flag_en;
  logic        r_flag_arith;
  logic        r_pcwrite;
  logic        r_pcsrc;
  logic        r_regwrite;
  logic        r_memwrite;
  logic        r_memtoreg;
  logic [1:0]  r_aluctl;
  logic [1:0]  r_alusrc;
  logic [1:0]  r_immsrc;
  logic [1:0]  r_regsrc;
  logic [3:0]  r_flags;
  logic        r_halted;
  logic        r_undef;

  logic [1:0]  w_alusrc;
  logic [1:0]  w_aluctl;
  logic [1:0]  w_immsrc;
  logic [1:0]  w_regsrc;
  logic        w_memtoreg;
  logic        w_branch;
  logic        w_regwr;
  logic        w_is_mem;
  logic        w_is_str;
  logic        w_flag_en;
  logic        w_flag_arith;
  logic        w_undef;
  logic        w_pass;
  logic        w_pcsrc;
  logic        w_halt;

  // Condition check on stored NZCV; the unconditional-extension space (1111) never passes.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'h0:    cond_ok = z;
      4'h1:    cond_ok = !z;
      4'h2:    cond_ok = cf;
      4'h3:    cond_ok = !cf;
      4'h4:    cond_ok = n;
      4'h5:    cond_ok = !n;
      4'h6:    cond_ok = v;
      4'h7:    cond_ok = !v;
      4'h8:    cond_ok = cf && !z;
      4'h9:    cond_ok = !cf || z;
      4'hA:    cond_ok = (n == v);
      4'hB:    cond_ok = (n != v);
      4'hC:    cond_ok = !z && (n == v);
      4'hD:    cond_ok = z || (n != v);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

  // Decode the word presented in FETCH so selects are valid from the first DECODE cycle.
  always_comb begin
    w_alusrc     = 2'b00;
    w_aluctl     = 2'b00;
    w_immsrc     = 2'b00;
    w_regsrc     = 2'b00;
    w_memtoreg   = 1'b0;
    w_branch     = 1'b0;
    w_regwr      = 1'b0;
    w_is_mem     = 1'b0;
    w_is_str     = 1'b0;
    w_flag_en    = 1'b0;
    w_flag_arith = 1'b0;
    w_undef      = 1'b0;
    case (Instr[27:26])
      2'b00: begin
        w_alusrc = {1'b0, Instr[25]};
        case (Instr[24:21])
          4'b0100: begin w_aluctl = 2'b00; w_regwr = 1'b1; w_flag_arith = 1'b1; w_flag_en = Instr[20]; end
          4'b0010: begin w_aluctl = 2'b01; w_regwr = 1'b1; w_flag_arith = 1'b1; w_flag_en = Instr[20]; end
          4'b0000: begin w_aluctl = 2'b10; w_regwr = 1'b1; w_flag_en = Instr[20]; end
          4'b1100: begin w_aluctl = 2'b11; w_regwr = 1'b1; w_flag_en = Instr[20]; end
          4'b1010: begin w_aluctl = 2'b01; w_flag_arith = 1'b1; w_flag_en = 1'b1; end
          default: w_undef = 1'b1;
        endcase
      end
      2'b01: begin
        w_alusrc = 2'b01;
        w_immsrc = 2'b01;
        w_aluctl = Instr[23] ? 2'b00 : 2'b01;
        w_is_mem = 1'b1;
        if (Instr[20]) begin
          w_memtoreg = 1'b1;
          w_regwr    = 1'b1;
        end else begin
          w_regsrc = 2'b10;
          w_is_str = 1'b1;
        end
        w_undef = Instr[25];
      end
      2'b10: begin
        w_alusrc = 2'b01;
        w_immsrc = 2'b10;
        w_regsrc = 2'b01;
        w_branch = 1'b1;
        w_undef  = Instr[24];
      end
      default: w_undef = 1'b1;
    endcase
  end

  assign w_halt  = (Instr == HALT_INSTR);
  assign w_pass  = cond_ok(Instr[31:28], r_flags) && !w_undef;
  assign w_pcsrc = w_pass && (w_branch || (w_regwr && (Instr[15:12] == 4'hF)));

  // State machine with registered control outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_ir         <= 32'h0;
      r_pass       <= 1'b0;
      r_mem        <= 1'b0;
      r_str        <= 1'b0;
      r_regwr      <= 1'b0;
      r_flag_en    <= 1'b0;
      r_flag_arith <= 1'b0;
      r_pcwrite    <= 1'b0;
      r_pcsrc      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_aluctl     <= 2'b00;
      r_alusrc     <= 2'b00;
      r_immsrc     <= 2'b00;
      r_regsrc     <= 2'b00;
      r_flags      <= 4'h0;
      r_halted     <= 1'b0;
      r_undef      <= 1'b0;
    end else begin
      r_pcwrite  <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_undef    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Run || AUTO_RUN) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir         <= Instr;
          r_state      <= S_DECODE;
          r_undef      <= w_undef && !w_halt;
          r_pass       <= w_pass && !w_halt;
          r_mem        <= w_is_mem;
          r_str        <= w_is_str;
          r_regwr      <= w_regwr && w_pass;
          r_flag_en    <= w_flag_en && w_pass;
          r_flag_arith <= w_flag_arith;
          if (!(w_halt || w_undef)) begin
            r_alusrc   <= w_alusrc;
            r_aluctl   <= w_aluctl;
            r_immsrc   <= w_immsrc;
            r_regsrc   <= w_regsrc;
            r_memtoreg <= w_memtoreg;
            r_pcsrc    <= w_pcsrc;
          end
        end
        S_DECODE: begin
          if (r_ir == HALT_INSTR) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (!r_pass) begin
            r_state   <= S_COMMIT;
            r_pcwrite <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_mem) begin
            r_state    <= S_MEM;
            r_memwrite <= r_str;
          end else begin
            r_state    <= S_COMMIT;
            r_pcwrite  <= 1'b1;
            r_regwrite <= r_regwr;
          end
        end
        S_MEM: begin
          r_state    <= S_COMMIT;
          r_pcwrite  <= 1'b1;
          r_regwrite <= r_regwr;
        end
        S_COMMIT: begin
          // Logical ops only touch N and Z; C and V carry over.
          if (r_flag_en) begin
            r_flags <= r_flag_arith ? ALUFlags : {ALUFlags[3:2], r_flags[1:0]};
          end
          r_alusrc   <= 2'b00;
          r_aluctl   <= 2'b00;
          r_immsrc   <= 2'b00;
          r_regsrc   <= 2'b00;
          r_memtoreg <= 1'b0;
          r_pcsrc    <= 1'b0;
          r_state    <= Run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset arriving mid-instruction must suppress a strobe already registered for this cycle.
  assign PCWrite    = r_pcwrite  & ~RST;
  assign RegWrite   = r_regwrite & ~RST;
  assign MemWrite   = r_memwrite & ~RST;
  assign PCSrc      = r_pcsrc;
  assign MemtoReg   = r_memtoreg;
  assign ALUControl = r_aluctl;
  assign ALUSrc     = r_alusrc;
  assign ImmSrc     = r_immsrc;
  assign RegSrc     = r_regsrc;
  assign Flags      = r_flags;
  assign Halted     = r_halted;
  assign Undef      = r_undef;

endmodule

// File: tb/tb_arm_multicycle_sequencer.sv
// Bench for arm_multicycle_sequencer: directed vector table, reset/halt corner cases,
// and random instructions checked cycle by cycle against an instruction-level model.
module tb_arm_multicycle_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Run = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, PCSrc, RegWrite, MemWrite, MemtoReg, Halted, Undef;
  logic [1:0]  ALUControl, ALUSrc, ImmSrc, RegSrc;
  logic [3:0]  Flags;

  arm_multicycle_sequencer dut (
    .CLK(CLK), .RST(RST), .Run(Run), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .Flags(Flags), .Halted(Halted), .Undef(Undef)
  );

  always #5 CLK = ~CLK;

  // {PCWrite,PCSrc,RegWrite,MemWrite,MemtoReg,ALUControl,ALUSrc,ImmSrc,RegSrc,Flags,Halted,Undef}
  logic [18:0] obs;
  always_comb obs = {PCWrite, PCSrc, RegWrite, MemWrite, MemtoReg, ALUControl, ALUSrc,
                     ImmSrc, RegSrc, Flags, Halted, Undef};

  typedef struct packed {
    logic [2:0] cyc;
    logic [1:0] alusrc;
    logic [1:0] aluctl;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic       m2r;
    logic       pcsrc;
    logic       regw;
    logic       memw;
    logic       undef;
    logic [3:0] flags_after;
  } rec_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  alu;
    rec_t        r;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [3:0]  m_flags  = 4'h0;
  vec_t        tbl[19];

  task automatic check(input string nm, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", nm, got, exp);
  endtask

  function automatic rec_t mkr(input int cyc, input logic [1:0] asrc, input logic [1:0] actl,
                               input logic [1:0] isrc, input logic [1:0] rsrc, input logic m2r,
                               input logic pcs, input logic rw, input logic mw, input logic ud,
                               input logic [3:0] fa);
    rec_t r;
    r.cyc = 3'(cyc); r.alusrc = asrc; r.aluctl = actl; r.immsrc = isrc; r.regsrc = rsrc;
    r.m2r = m2r; r.pcsrc = pcs; r.regw = rw; r.memw = mw; r.undef = ud; r.flags_after = fa;
    return r;
  endfunction

  // Instruction-level reference: what an instruction does, given flags before it.
  function automatic rec_t model(input logic [31:0] ins, input logic [3:0] fl, input logic [3:0] alu);
    rec_t r;
    bit n, z, c, v, ok, ud, wr, setf, arith;
    logic [3:0] cmd;
    n = fl[3]; z = fl[2]; c = fl[1]; v = fl[0];
    case (ins[31:28])
      0: ok = z;             1: ok = !z;
      2: ok = c;             3: ok = !c;
      4: ok = n;             5: ok = !n;
      6: ok = v;             7: ok = !v;
      8: ok = c && !z;       9: ok = !c || z;
      10: ok = n == v;       11: ok = n != v;
      12: ok = !z && n == v; 13: ok = z || n != v;
      14: ok = 1;            default: ok = 0;
    endcase
    r = '0;
    ud = 0; wr = 0; setf = 0; arith = 0;
    r.cyc = 3'd4;
    cmd = ins[24:21];
    if (ins[27:26] == 2'b00) begin
      r.alusrc = {1'b0, ins[25]};
      setf = ins[20];
      wr = 1;
      if (cmd == 4) begin r.aluctl = 0; arith = 1; end
      else if (cmd == 2) begin r.aluctl = 1; arith = 1; end
      else if (cmd == 0) r.aluctl = 2;
      else if (cmd == 12) r.aluctl = 3;
      else if (cmd == 10) begin r.aluctl = 1; arith = 1; setf = 1; wr = 0; end
      else ud = 1;
    end else if (ins[27:26] == 2'b01) begin
      r.cyc = 3'd5; r.alusrc = 1; r.immsrc = 1;
      r.aluctl = ins[23] ? 2'd0 : 2'd1;
      if (ins[20]) begin r.m2r = 1; wr = 1; end
      else begin r.regsrc = 2; r.memw = 1; end
      ud = ins[25];
    end else if (ins[27:26] == 2'b10) begin
      r.alusrc = 1; r.immsrc = 2; r.regsrc = 1; r.pcsrc = 1;
      ud = ins[24];
    end else ud = 1;
    r.flags_after = fl;
    if (ud) begin
      r = '0; r.undef = 1; r.cyc = 3'd3; r.flags_after = fl;
    end else if (!ok) begin
      r.cyc = 3'd3; r.pcsrc = 0; r.memw = 0; r.regw = 0;
    end else begin
      r.regw = wr;
      if (wr && ins[15:12] == 4'hF) r.pcsrc = 1;
      if (setf) r.flags_after = arith ? alu : {alu[3:2], fl[1:0]};
    end
    return r;
  endfunction

  // Expected observation in cycle k of an instruction (k=0 is FETCH).
  function automatic logic [18:0] exp_obs(input rec_t r, input int k, input logic [3:0] fl);
    logic last;
    last = (k == int'(r.cyc) - 1);
    if (k == 0) return {15'h0, fl, 2'b00};
    return {last, r.pcsrc, r.regw && last, r.memw && (k == 3) && (r.cyc == 3'd5), r.m2r,
            r.aluctl, r.alusrc, r.immsrc, r.regsrc, fl, 1'b0, r.undef && (k == 1)};
  endfunction

  // Precondition: DUT has just entered FETCH. Leaves it just after entering the next FETCH.
  task automatic exec_check(input string nm, input logic [31:0] ins, input logic [3:0] alu,
                            input rec_t r);
    Instr = ins; ALUFlags = alu;
    for (int k = 0; k < int'(r.cyc); k++) begin
      @(negedge CLK);
      check($sformatf("%s_c%0d", nm, k), obs, exp_obs(r, k, m_flags));
      if (k < int'(r.cyc) - 1) @(posedge CLK);
    end
    m_flags = r.flags_after;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input string nm);
    RST = 1; Run = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check(nm, obs, 19'h0);
    RST = 0;
    @(posedge CLK);
    #1;
    m_flags = 4'h0;
  endtask

  initial begin
    rec_t r;
    logic [31:0] ins;
    logic [3:0]  alu;
    logic [3:0]  cmd_tab[6];

    tbl[0]  = '{32'hE2810005, 4'h0, mkr(4, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'b0000)};
    tbl[1]  = '{32'hE3500000, 4'h4, mkr(4, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'b0100)};
    tbl[2]  = '{32'h0A000002, 4'h0, mkr(4, 2'b01, 2'b00, 2'b10, 2'b01, 0, 1, 0, 0, 0, 4'b0100)};
    tbl[3]  = '{32'hE5912004, 4'h0, mkr(5, 2'b01, 2'b00, 2'b01, 2'b00, 1, 0, 1, 0, 0, 4'b0100)};
    tbl[4]  = '{32'hE5812004, 4'h0, mkr(5, 2'b01, 2'b00, 2'b01, 2'b10, 0, 0, 0, 1, 0, 4'b0100)};
    tbl[5]  = '{32'hE3500000, 4'h0, mkr(4, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'b0000)};
    tbl[6]  = '{32'h02810001, 4'hF, mkr(3, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'b0000)};
    tbl[7]  = '{32'hE7000000, 4'hF, mkr(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4'b0000)};
    tbl[8]  = '{32'hE3910000, 4'hF, mkr(4, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'b1100)};
    tbl[9]  = '{32'hE28FF004, 4'h0, mkr(4, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 0, 4'b1100)};
    tbl[10] = '{32'hF2810005, 4'h0, mkr(3, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 4'b1100)};
    tbl[11] = '{32'hE0410002, 4'h3, mkr(4, 2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'b1100)};
    tbl[12] = '{32'hE5112004, 4'h0, mkr(5, 2'b01, 2'b01, 2'b01, 2'b00, 1, 0, 1, 0, 0, 4'b1100)};
    tbl[13] = '{32'hEB000000, 4'h0, mkr(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4'b1100)};
    tbl[14] = '{32'hEC000000, 4'h0, mkr(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4'b1100)};
    tbl[15] = '{32'hE1A00000, 4'h0, mkr(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 4'b1100)};
    tbl[16] = '{32'hE2911001, 4'h3, mkr(4, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'b0011)};
    tbl[17] = '{32'hE2111000, 4'hE, mkr(4, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'b1111)};
    tbl[18] = '{32'h1A000001, 4'h0, mkr(3, 2'b01, 2'b00, 2'b10, 2'b01, 0, 0, 0, 0, 0, 4'b1111)};

    do_reset("reset");
    for (int i = 0; i < 19; i++)
      exec_check($sformatf("vec%0d", i), tbl[i].ins, tbl[i].alu, tbl[i].r);

    // Reset during MEM of a STR: strobe suppressed, everything cleared including Flags.
    r = mkr(5, 2'b01, 2'b00, 2'b01, 2'b10, 0, 0, 0, 1, 0, 4'b1111);
    Instr = 32'hE5812004; ALUFlags = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("rstmem_c%0d", k), obs, exp_obs(r, k, m_flags));
      @(posedge CLK);
    end
    #1 RST = 1;
    @(negedge CLK);
    check("rstmem_memwrite", {18'h0, MemWrite}, 19'h0);
    @(posedge CLK);
    @(negedge CLK);
    check("rstmem_cleared", obs, 19'h0);
    RST = 0; Run = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("rstmem_idle%0d", k), obs, 19'h0);
    end
    Run = 1;
    @(posedge CLK);
    #1;
    m_flags = 4'h0;
    exec_check("after_rst", 32'hE2810005, 4'h0,
               mkr(4, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 4'b0000));

    // HALT is sticky with Run held high and no strobes.
    Instr = 32'hEF000000; ALUFlags = 4'hF;
    @(negedge CLK);
    check("halt_fetch", obs, 19'h0);
    @(posedge CLK);
    @(negedge CLK);
    check("halt_decode", obs, 19'h0);
    Instr = 32'hE2810005;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check($sformatf("halt_hold%0d", k), obs, 19'h2);
    end

    do_reset("reset2");
    cmd_tab[0] = 4'h4; cmd_tab[1] = 4'h2; cmd_tab[2] = 4'h0;
    cmd_tab[3] = 4'hC; cmd_tab[4] = 4'hA; cmd_tab[5] = 4'h0;
    for (int i = 0; i < 150; i++) begin
      int cls;
      cls = int'($urandom_range(0, 9));
      ins = $urandom;
      if (cls < 4) begin
        ins[27:26] = 2'b00;
        if ($urandom_range(0, 7) != 0) ins[24:21] = cmd_tab[$urandom_range(0, 5)];
      end else if (cls < 7) begin
        ins[27:26] = 2'b01;
        ins[25] = ($urandom_range(0, 7) == 0);
      end else if (cls < 9) begin
        ins[27:26] = 2'b10;
        ins[24] = ($urandom_range(0, 5) == 0);
      end else ins[27:26] = 2'b11;
      if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
      if (ins == 32'hEF000000) ins[0] = 1'b1;
      alu = 4'($urandom);
      exec_check($sformatf("rnd%0d_%08h", i, ins), ins, alu, model(ins, m_flags, alu));
    end
    @(negedge CLK);
    check("final_flags", {15'h0, Flags}, {15'h0, m_flags});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
